trp_ctrl: RTL and testbench

- Sequencer that drives the transposer buffer (trp_fifo) from the initiator side.
- Accepts one BUFFD-row tile on a valid/ready input stream and writes it into the buffer row by row.
- Then issues column reads and forwards the transposed rows on a valid/ready output stream with back-pressure.
- Owns ffinit/ffwreq/ffrreq/mode toward the buffer and consumes ffrdata/ffrvld.

---
 rtl/trp_ctrl.sv | 170 +++++++++++++++++
 tb/tb_trp_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trp_ctrl.sv
// Transposer sequencer: loads one BUFFD-row tile into trp_fifo, then reads it back
// column-wise and streams the transposed rows out through a 2-entry skid buffer.
module trp_ctrl #(
    parameter int BUFFD = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [BUFFD*8-1:0]   in_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [BUFFD*8-1:0]   out_data,
    output logic                 out_last,
    output logic [1:0]           ff_mode,
    output logic                 ffinit,
    output logic                 ffwreq,
    output logic [BUFFD*8-1:0]   ffwdata,
    output logic                 ffrreq,
    input  logic [BUFFD*8-1:0]   ffrdata,
    input  logic                 ffrvld
);

    localparam int DW = BUFFD * 8;
    localparam int WW = $clog2(BUFFD);
    localparam int CW = WW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FILL,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic [CW-1:0]   ocnt_q, ocnt_d;
    logic            infl_q, infl_d;
    logic [1:0]      occ_q, occ_d;
    logic            wptr_q, wptr_d;
    logic            rptr_q, rptr_d;
    logic [DW-1:0]   skid_q [2];

    logic            mode_ok;
    logic            push;
    logic            pop;
    logic [CW-1:0]   nr;
    logic [2:0]      pending;

    assign mode_ok = (mode == 2'b01) || (mode == 2'b10);
    assign nr      = (mode_q == 2'b10) ? CW'(BUFFD / 4) : CW'(BUFFD);
    assign ff_mode = mode_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        ffinit   = (state_q == S_INIT);
        in_rdy   = (state_q == S_FILL);
        err      = (state_q == S_IDLE) && start && !mode_ok;
        ffwreq   = in_rdy && in_vld;
        ffwdata  = in_data;
        out_vld  = (state_q == S_DRAIN) && (occ_q != 2'd0);
        out_data = out_vld ? skid_q[rptr_q] : '0;
        out_last = out_vld && (ocnt_q == nr - CW'(1));
        pop      = out_vld && out_rdy;
        push     = (state_q == S_DRAIN) && ffrvld;
        // A read issued now lands next cycle; count this cycle's pop so a full
        // pipeline keeps one row per cycle without ever overrunning the skid.
        pending  = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
        ffrreq   = (state_q == S_DRAIN) && (rcnt_q < nr) && (pending < 3'd2);

        state_d  = state_q;
        mode_d   = mode_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        ocnt_d   = ocnt_q;
        infl_d   = ffrreq;
        occ_d    = occ_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;

        case (state_q)
            S_IDLE: begin
                if (start && mode_ok) begin
                    mode_d  = mode;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                wcnt_d  = '0;
                rcnt_d  = '0;
                ocnt_d  = '0;
                occ_d   = '0;
                wptr_d  = 1'b0;
                rptr_d  = 1'b0;
                state_d = S_FILL;
            end
            S_FILL: begin
                if (ffwreq) begin
                    wcnt_d = wcnt_q + WW'(1);
                    if (wcnt_q == WW'(BUFFD - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (ffrreq) begin
                    rcnt_d = rcnt_q + CW'(1);
                end
                occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
                wptr_d = wptr_q ^ push;
                rptr_d = rptr_q ^ pop;
                if (pop) begin
                    ocnt_d = ocnt_q + CW'(1);
                    if (out_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            ocnt_q  <= '0;
            infl_q  <= 1'b0;
            occ_q   <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            ocnt_q  <= ocnt_d;
            infl_q  <= infl_d;
            occ_q   <= occ_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // NOTE: skid storage is not reset; occupancy gates its use and out_data is masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            skid_q[wptr_q] <= ffrdata;
        end
    end

endmodule

// File: tb/tb_trp_ctrl.sv
// Directed bench for trp_ctrl (BUFFD=8) with a behavioural trp_fifo responder.
module tb_trp_ctrl;

    localparam int BUFFD = 8;
    localparam int DW    = BUFFD * 8;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic          busy, done, err;
    logic          in_vld, in_rdy;
    logic [DW-1:0] in_data;
    logic          out_vld, out_rdy, out_last;
    logic [DW-1:0] out_data;
    logic [1:0]    ff_mode;
    logic          ffinit, ffwreq, ffrreq;
    logic [DW-1:0] ffwdata;
    logic [DW-1:0] ffrdata = '0;
    logic          ffrvld  = 1'b0;

    trp_ctrl #(.BUFFD(BUFFD)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_last (out_last),
        .ff_mode  (ff_mode),
        .ffinit   (ffinit),
        .ffwreq   (ffwreq),
        .ffwdata  (ffwdata),
        .ffrreq   (ffrreq),
        .ffrdata  (ffrdata),
        .ffrvld   (ffrvld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Input row r carries byte value 8r+c in byte c.
    function automatic logic [63:0] row(input int r);
        logic [63:0] v;
        for (int c = 0; c < 8; c++) v[8*c +: 8] = 8'(8 * r + c);
        return v;
    endfunction

    // Expected transposed beat, written directly from the byte numbering above.
    function automatic logic [63:0] exp_beat(input logic [1:0] m, input int k);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) begin
            if (m == 2'b10) v[8*i +: 8] = 8'(8 * (i / 4) + 4 * k + (i % 4));
            else            v[8*i +: 8] = 8'(8 * i + k);
        end
        return v;
    endfunction

    // Behavioural transposer buffer: stores written rows, returns columns one cycle after ffrreq.
    logic [63:0] bufm [8];
    int wp = 0;
    int rp = 0;

    function automatic logic [63:0] col_read(input logic [1:0] m, input int k);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) begin
            if (m == 2'b10) v[8*i +: 8] = bufm[i / 4][8 * ((4 * k + (i % 4)) & 7) +: 8];
            else            v[8*i +: 8] = bufm[i][8 * (k & 7) +: 8];
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (ffinit) begin
            wp     <= 0;
            rp     <= 0;
            ffrvld <= 1'b0;
        end else begin
            ffrvld <= ffrreq;
            if (ffwreq && wp < 8) begin
                bufm[wp] <= ffwdata;
                wp       <= wp + 1;
            end
            if (ffrreq) begin
                ffrdata <= col_read(ff_mode, rp);
                rp      <= rp + 1;
            end
        end
    end

    // Event counters seen at the active edge.
    int n_init = 0, n_wr = 0, n_rd = 0, n_acc = 0, n_err = 0;
    int max_out = 0, n_overlap = 0, n_early = 0;

    always @(posedge clk) begin
        n_init <= n_init + int'(ffinit);
        n_wr   <= n_wr + int'(ffwreq);
        n_rd   <= n_rd + int'(ffrreq);
        n_acc  <= n_acc + int'(out_vld & out_rdy);
        n_err  <= n_err + int'(err);
        if ((n_rd + int'(ffrreq)) - (n_acc + int'(out_vld & out_rdy)) > max_out)
            max_out <= (n_rd + int'(ffrreq)) - (n_acc + int'(out_vld & out_rdy));
        if (ffwreq && ffrreq) n_overlap <= n_overlap + 1;
        if (ffrreq && wp < 8) n_early <= n_early + 1;
    end

    task automatic do_tile(input logic [1:0] m, input bit stall, input bit poke);
        int i0, w0, r0, e0, nr, r, c, nb, first_v, last_c;
        bit held, fin;
        logic [63:0] hold_d;
        logic hold_l;
        nr = (m == 2'b10) ? 2 : 8;
        i0 = n_init; w0 = n_wr; r0 = n_rd; e0 = n_err;

        @(negedge clk); start = 1'b1; mode = m;
        @(negedge clk); start = 1'b0; mode = 2'b00;
        #1;
        check("init_ffinit", 64'(ffinit), 64'(1));
        check("init_busy", 64'(busy), 64'(1));
        check("init_ff_mode", 64'(ff_mode), 64'(m));

        r = 0; c = 0;
        while (r < 8 && c < 100) begin
            @(negedge clk);
            in_vld  = 1'b1;
            in_data = row(r);
            start   = poke && (r == 3);
            mode    = poke ? 2'b10 : 2'b00;
            #1;
            if (poke && r == 3) check("err_while_busy", 64'(err), 64'(0));
            if (in_rdy) begin
                if (r == 0) check("ffwdata_pass", ffwdata, row(0));
                r++;
            end
            c++;
        end
        check("fill_rows", 64'(r), 64'(8));

        nb = 0; first_v = -1; last_c = -1; held = 1'b0; fin = 1'b0; c = 0;
        hold_d = '0; hold_l = 1'b0;
        while (!fin && c < 200) begin
            @(negedge clk);
            in_vld  = 1'b0;
            start   = 1'b0;
            mode    = 2'b00;
            out_rdy = stall ? ((c % 2 == 0) && !(c >= 6 && c < 11)) : 1'b1;
            #1;
            if (c == 0) check("in_rdy_drain", 64'(in_rdy), 64'(0));
            if (out_vld && first_v < 0) first_v = c;
            if (held) begin
                check("stall_vld", 64'(out_vld), 64'(1));
                check("stall_data", out_data, hold_d);
                check("stall_last", 64'(out_last), 64'(hold_l));
            end
            held   = out_vld && !out_rdy;
            hold_d = out_data;
            hold_l = out_last;
            if (out_vld && out_rdy) begin
                check("beat_data", out_data, exp_beat(m, nb));
                check("beat_last", 64'(out_last), 64'(nb == nr - 1));
                check("drain_ff_mode", 64'(ff_mode), 64'(m));
                nb++;
                if (out_last) begin
                    fin    = 1'b1;
                    last_c = c;
                end
            end
            c++;
        end
        check("beats", 64'(nb), 64'(nr));
        check("first_vld_cycle", 64'(first_v), 64'(2));
        if (!stall) check("last_beat_cycle", 64'(last_c), 64'(nr + 1));

        @(negedge clk); #1;
        check("done_pulse", 64'(done), 64'(1));
        check("done_busy", 64'(busy), 64'(1));
        @(negedge clk); #1;
        check("done_clear", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));

        check("cnt_ffinit", 64'(n_init - i0), 64'(1));
        check("cnt_ffwreq", 64'(n_wr - w0), 64'(8));
        check("cnt_ffrreq", 64'(n_rd - r0), 64'(nr));
        check("cnt_err", 64'(n_err - e0), 64'(0));
        check("max_outstanding_le2", 64'(max_out <= 2), 64'(1));
        check("no_wr_rd_overlap", 64'(n_overlap), 64'(0));
        check("no_early_read", 64'(n_early), 64'(0));
        out_rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, w0;
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 2'b00;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("rst_ctrl_outs",
              64'({busy, done, err, in_rdy, out_vld, out_last, ffinit, ffwreq, ffrreq}), 64'(0));
        check("rst_ff_mode", 64'(ff_mode), 64'(0));
        check("rst_out_data", out_data, 64'(0));
        @(negedge clk); reset = 1'b0;

        // 8-bit transpose, full rate.
        do_tile(2'b01, 1'b0, 1'b0);
        // 32-bit transpose, full rate.
        do_tile(2'b10, 1'b0, 1'b0);
        // 8-bit transpose with toggling and held-low back-pressure.
        do_tile(2'b01, 1'b1, 1'b0);

        // Illegal mode in IDLE.
        i0 = n_init;
        @(negedge clk); start = 1'b1; mode = 2'b11;
        #1;
        check("err_pulse", 64'(err), 64'(1));
        check("err_busy", 64'(busy), 64'(0));
        @(negedge clk); start = 1'b0; mode = 2'b00;
        #1;
        check("err_clear", 64'(err), 64'(0));
        check("err_no_busy", 64'(busy), 64'(0));
        check("err_no_ffinit", 64'(ffinit), 64'(0));
        @(negedge clk); #1;
        check("err_no_init_cnt", 64'(n_init - i0), 64'(0));

        // Start during FILL must be ignored.
        do_tile(2'b01, 1'b0, 1'b1);

        // Reset after three writes, then a clean tile.
        w0 = n_wr;
        @(negedge clk); start = 1'b1; mode = 2'b01;
        @(negedge clk); start = 1'b0; mode = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); in_vld = 1'b1; in_data = row(k);
        end
        @(negedge clk); reset = 1'b1; in_vld = 1'b0;
        @(negedge clk); reset = 1'b0;
        #1;
        check("midrst_writes", 64'(n_wr - w0), 64'(3));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_in_rdy", 64'(in_rdy), 64'(0));
        check("midrst_out_vld", 64'(out_vld), 64'(0));
        check("midrst_ff_mode", 64'(ff_mode), 64'(0));
        do_tile(2'b01, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
